// File: rtl/mult_arbiter.sv
// Four-way round-robin front end for a single shared 8x8 multiplier.
// One operation is in flight at a time: grant, wait MUL_LAT cycles, hold the result until it is accepted.
module mult_arbiter #(
   parameter int unsigned MUL_LAT = 1,
   parameter logic [15:0] MUL_M   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic [3:0]  gnt,
   output logic [7:0]  mul_a,
   output logic [7:0]  mul_b,
   output logic [15:0] mul_m,
   input  logic [16:0] mul_res,
   output logic        res_valid,
   output logic [15:0] res_data,
   output logic [1:0]  res_id,
   input  logic        res_ready,
   output logic        busy,
   output logic        ovf_err
);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] ptr;
   logic [1:0] winner;
   logic [1:0] idx;
   logic       found;
   logic [3:0] cnt;

   assign mul_m = MUL_M;

   // Search starts just after the previous winner, so the last one served has lowest priority.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req != 4'b0000) state_next = WAIT;
         WAIT:    if (cnt == 4'd0)    state_next = HOLD;
         HOLD:    if (res_ready)      state_next = IDLE;
         default:                     state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // busy follows the next state so it is a flop that lines up with the state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= 2'd3;
         cnt       <= 4'd0;
         gnt       <= 4'b0000;
         mul_a     <= 8'h00;
         mul_b     <= 8'h00;
         res_valid <= 1'b0;
         res_data  <= 16'h0000;
         res_id    <= 2'd0;
         busy      <= 1'b0;
         ovf_err   <= 1'b0;
      end else begin
         gnt  <= 4'b0000;
         busy <= (state_next != IDLE);
         case (state)
            IDLE: begin
               if (req != 4'b0000) begin
                  gnt    <= 4'b0001 << winner;
                  mul_a  <= a_in[{winner, 3'b000} +: 8];
                  mul_b  <= b_in[{winner, 3'b000} +: 8];
                  res_id <= winner;
                  ptr    <= winner;
                  cnt    <= CNT_INIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  res_data  <= mul_res[15:0];
                  res_valid <= 1'b1;
                  if (mul_res[16]) ovf_err <= 1'b1;
               end
            end
            HOLD: begin
               if (res_ready) res_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 1: cycles allowed from operand launch to sampling mul_res; legal range 1..15.
REQ-002 Parameter MUL_M, default 16'h0000: constant word driven on mul_m.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req  input  4  per-requester request, bit i = requester i.
REQ-006 a_in  input  32  requester i operand A on bits [8i+7:8i].
REQ-007 b_in  input  32  requester i operand B on bits [8i+7:8i].
REQ-008 gnt  output  4  one-hot, one-cycle acceptance pulse to the selected requester.
REQ-009 mul_a  output  8  registered operand A to the shared multiplier datapath.
REQ-010 mul_b  output  8  registered operand B to the shared multiplier datapath.
REQ-011 mul_m  output  16  equals MUL_M at all times.
REQ-012 mul_res  input  17  multiplier result.
REQ-013 res_valid  output  1  result available.
REQ-014 res_data  output  16  product, mul_res[15:0] as captured.
REQ-015 res_id  output  2  index of the requester that owns res_data.
REQ-016 res_ready  input  1  consumer accepts the result.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 ovf_err  output  1  sticky flag, set when a captured mul_res[16] is 1.

Function
REQ-019 FSM states: IDLE, WAIT, HOLD; all outputs registered except mul_m.
REQ-020 IDLE, req==0: stay in IDLE, no outputs change.
REQ-021 IDLE, req!=0, at edge E0:
- select winner w by round-robin: priority order ptr+1, ptr+2, ptr+3, ptr (mod 4);
- load mul_a/mul_b from w's slice;
- set res_id=w and ptr=w;
- set cnt=MUL_LAT-1;
- assert gnt[w] for exactly the cycle following E0;
- go to WAIT.
REQ-022 WAIT, cnt!=0: decrement cnt; mul_a and mul_b are held stable.
REQ-023 WAIT, cnt==0 at edge: capture res_data=mul_res[15:0]; set ovf_err if mul_res[16]; set res_valid=1; go to HOLD.
REQ-024 Capture latency: res_valid is high in the cycle after edge E0+MUL_LAT, where E0 is the edge that sampled the request.
REQ-025 HOLD: res_valid, res_data and res_id are held stable until an edge with res_ready=1.
REQ-026 HOLD with res_ready=1: clear res_valid and return to IDLE; arbitration restarts at the next edge.
REQ-027 Throughput: one operation per MUL_LAT+2 cycles maximum when res_ready is held high.
REQ-028 req is sampled only in IDLE; req changes in WAIT or HOLD are ignored.
REQ-029 Requester obligation: hold req and operands stable until gnt, then drop req; a req still high at the next IDLE is a new request.
REQ-030 Simultaneous requests: exactly one grant per operation; every continuously requesting requester is served within 4 operations.
REQ-031 Any res_ready value is ignored outside HOLD.
REQ-032 ovf_err is cleared only by reset.

Reset
REQ-033 Reset values at any edge with rst_n=0, regardless of state:
- state=IDLE, ptr=3, cnt=0;
- gnt=0, mul_a=0, mul_b=0;
- res_valid=0, res_data=0, res_id=0;
- busy=0, ovf_err=0.
REQ-034 Reset mid-operation discards the in-flight operation; no res_valid is produced for it after reset releases.

Verification
REQ-035 Single request, MUL_LAT=1: req=4'b0001, A=8'hFF, B=8'hFF, res_ready=1 -> gnt=0001 one cycle; res_valid after E0+1 with res_data=16'hFE01 and res_id=0.
REQ-036 Round-robin: req=4'b1111 held, ptr at reset -> grant order 0,1,2,3,0.
REQ-037 Backpressure: res_ready=0 for 5 cycles in HOLD -> res_valid, res_data and res_id stay stable; IDLE is re-entered only after the res_ready edge.
REQ-038 MUL_LAT=3: A=8'd12, B=8'd11 -> mul_a/mul_b stable 3 cycles; res_data=16'd132 valid after E0+3.
REQ-039 Reset in WAIT: rst_n=0 one edge -> all outputs at reset values; no res_valid afterwards.
REQ-040 Overflow injection: mul_res=17'h10000 during WAIT -> ovf_err=1, held until reset.
